// File: rtl/gate_timer_master_if.sv
// Bus between the gate timer master and its memory-mapped timer slave.
interface gate_timer_master_if;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        irq;

    modport master (
        output av_address,
        output av_chipselect,
        output av_write_n,
        output av_writedata,
        input  av_readdata,
        input  irq
    );

    modport slave (
        input  av_address,
        input  av_chipselect,
        input  av_write_n,
        input  av_writedata,
        output av_readdata,
        output irq
    );
endinterface

// File: rtl/gate_timer_master.sv
// Drives a memory-mapped timer slave: programs period and mode, services
// timeouts, captures counter snapshots and performs an orderly stop.
module gate_timer_master (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic [31:0]         cmd_period,
    input  logic                cmd_continuous,
    input  logic                snap_req,
    gate_timer_master_if.master bus,
    output logic                busy,
    output logic                tick,
    output logic [15:0]         tick_count,
    output logic [31:0]         snap_value,
    output logic                snap_valid,
    output logic                err_overrun
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_PL    = 4'd1;
    localparam logic [3:0] S_WR_PH    = 4'd2;
    localparam logic [3:0] S_WR_CTRL  = 4'd3;
    localparam logic [3:0] S_RUN      = 4'd4;
    localparam logic [3:0] S_CLR_ST   = 4'd5;
    localparam logic [3:0] S_SNAP_WR  = 4'd6;
    localparam logic [3:0] S_SNAP_RL  = 4'd7;
    localparam logic [3:0] S_SNAP_RH  = 4'd8;
    localparam logic [3:0] S_SNAP_CAP = 4'd9;
    localparam logic [3:0] S_STOP_WR  = 4'd10;
    localparam logic [3:0] S_STOP_CLR = 4'd11;

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_PER_L  = 3'd2;
    localparam logic [2:0] A_PER_H  = 3'd3;
    localparam logic [2:0] A_SNAP_L = 3'd4;
    localparam logic [2:0] A_SNAP_H = 3'd5;

    localparam logic [15:0] CTRL_RUN_CONT = 16'h0007;
    localparam logic [15:0] CTRL_RUN_ONCE = 16'h0005;
    localparam logic [15:0] CTRL_STOP     = 16'h0008;

    logic [3:0]  state_q,        state_d;
    logic [31:0] period_q,       period_d;
    logic        cont_q,         cont_d;
    logic        snap_pend_q,    snap_pend_d;
    logic        stop_pend_q,    stop_pend_d;
    logic        busy_q,         busy_d;
    logic        tick_q,         tick_d;
    logic [15:0] tick_count_q,   tick_count_d;
    logic [31:0] snap_value_q,   snap_value_d;
    logic        snap_valid_q,   snap_valid_d;
    logic        err_overrun_q,  err_overrun_d;
    logic [2:0]  av_address_q,   av_address_d;
    logic        av_cs_q,        av_cs_d;
    logic        av_write_n_q,   av_write_n_d;
    logic [15:0] av_writedata_q, av_writedata_d;

    logic accept;
    logic in_setup;
    logic in_snap;

    assign accept   = (state_q == S_IDLE) && cmd_start;
    assign in_setup = state_q inside {S_WR_PL, S_WR_PH, S_WR_CTRL};
    assign in_snap  = state_q inside {S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (cmd_start) state_d = S_WR_PL;
            S_WR_PL:    state_d = S_WR_PH;
            S_WR_PH:    state_d = S_WR_CTRL;
            S_WR_CTRL:  state_d = S_RUN;
            S_RUN: begin
                if (cmd_stop || stop_pend_q) state_d = S_STOP_WR;
                else if (bus.irq)            state_d = S_CLR_ST;
                else if (snap_pend_q)        state_d = S_SNAP_WR;
            end
            S_CLR_ST:   state_d = cont_q ? S_RUN : S_STOP_CLR;
            S_SNAP_WR:  state_d = S_SNAP_RL;
            S_SNAP_RL:  state_d = S_SNAP_RH;
            S_SNAP_RH:  state_d = S_SNAP_CAP;
            S_SNAP_CAP: state_d = S_RUN;
            S_STOP_WR:  state_d = S_STOP_CLR;
            S_STOP_CLR: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        period_d      = accept ? cmd_period : period_q;
        cont_d        = accept ? cmd_continuous : cont_q;
        busy_d        = (state_d != S_IDLE);
        tick_d        = (state_d == S_CLR_ST);
        tick_count_d  = tick_count_q;
        snap_value_d  = snap_value_q;
        snap_valid_d  = 1'b0;
        err_overrun_d = err_overrun_q;
        snap_pend_d   = snap_pend_q;
        stop_pend_d   = stop_pend_q;

        if (accept)                      tick_count_d = '0;
        else if (state_d == S_CLR_ST)    tick_count_d = tick_count_q + 16'd1;

        if (accept)                      err_overrun_d = 1'b0;
        else if (in_snap && bus.irq)     err_overrun_d = 1'b1;

        // Clearing on SNAP_WR entry wins so a request arriving that same cycle collapses into it.
        if (state_d == S_SNAP_WR || state_d == S_IDLE)
            snap_pend_d = 1'b0;
        else if (snap_req && state_q != S_IDLE)
            snap_pend_d = 1'b1;

        if (state_d == S_STOP_WR || state_d == S_IDLE)
            stop_pend_d = 1'b0;
        else if (cmd_stop && in_setup)
            stop_pend_d = 1'b1;

        // Slave read data lags the address by one cycle, hence capture on leaving RH/CAP.
        if (state_q == S_SNAP_RH)
            snap_value_d[15:0] = bus.av_readdata;
        if (state_q == S_SNAP_CAP) begin
            snap_value_d[31:16] = bus.av_readdata;
            snap_valid_d        = 1'b1;
        end
    end

    // Bus outputs are decoded from the next state so they are registered yet valid in-state.
    always_comb begin
        av_address_d   = '0;
        av_cs_d        = 1'b0;
        av_write_n_d   = 1'b1;
        av_writedata_d = '0;
        case (state_d)
            S_WR_PL: begin
                av_cs_d = 1'b1; av_write_n_d = 1'b0;
                av_address_d = A_PER_L; av_writedata_d = period_d[15:0];
            end
            S_WR_PH: begin
                av_cs_d = 1'b1; av_write_n_d = 1'b0;
                av_address_d = A_PER_H; av_writedata_d = period_d[31:16];
            end
            S_WR_CTRL: begin
                av_cs_d = 1'b1; av_write_n_d = 1'b0;
                av_address_d = A_CTRL;
                av_writedata_d = cont_d ? CTRL_RUN_CONT : CTRL_RUN_ONCE;
            end
            S_CLR_ST, S_STOP_CLR: begin
                av_cs_d = 1'b1; av_write_n_d = 1'b0;
                av_address_d = A_STATUS;
            end
            S_SNAP_WR: begin
                av_cs_d = 1'b1; av_write_n_d = 1'b0;
                av_address_d = A_SNAP_L;
            end
            S_SNAP_RL: begin
                av_cs_d = 1'b1;
                av_address_d = A_SNAP_L;
            end
            S_SNAP_RH: begin
                av_cs_d = 1'b1;
                av_address_d = A_SNAP_H;
            end
            S_STOP_WR: begin
                av_cs_d = 1'b1; av_write_n_d = 1'b0;
                av_address_d = A_CTRL; av_writedata_d = CTRL_STOP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            period_q       <= '0;
            cont_q         <= 1'b0;
            snap_pend_q    <= 1'b0;
            stop_pend_q    <= 1'b0;
            busy_q         <= 1'b0;
            tick_q         <= 1'b0;
            tick_count_q   <= '0;
            snap_value_q   <= '0;
            snap_valid_q   <= 1'b0;
            err_overrun_q  <= 1'b0;
            av_address_q   <= '0;
            av_cs_q        <= 1'b0;
            av_write_n_q   <= 1'b1;
            av_writedata_q <= '0;
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            cont_q         <= cont_d;
            snap_pend_q    <= snap_pend_d;
            stop_pend_q    <= stop_pend_d;
            busy_q         <= busy_d;
            tick_q         <= tick_d;
            tick_count_q   <= tick_count_d;
            snap_value_q   <= snap_value_d;
            snap_valid_q   <= snap_valid_d;
            err_overrun_q  <= err_overrun_d;
            av_address_q   <= av_address_d;
            av_cs_q        <= av_cs_d;
            av_write_n_q   <= av_write_n_d;
            av_writedata_q <= av_writedata_d;
        end
    end

    assign bus.av_address    = av_address_q;
    assign bus.av_chipselect = av_cs_q;
    assign bus.av_write_n    = av_write_n_q;
    assign bus.av_writedata  = av_writedata_q;
    assign busy              = busy_q;
    assign tick              = tick_q;
    assign tick_count        = tick_count_q;
    assign snap_value        = snap_value_q;
    assign snap_valid        = snap_valid_q;
    assign err_overrun       = err_overrun_q;

endmodule

// File: doc/gate_timer_master.md
GATE_TIMER_MASTER -- requirements
Module: gate_timer_master

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock); reset_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have command ports: cmd_start in 1 (pulse); cmd_stop in 1 (pulse); cmd_period in 32 (timer period, minus 1); cmd_continuous in 1 (free-run vs one-shot); snap_req in 1 (pulse).
REQ-003 SHALL have timer-bus master ports: av_address out 3; av_chipselect out 1; av_write_n out 1 (low = write); av_writedata out 16; av_readdata in 16 (registered in the slave, valid the cycle after the address is presented); irq in 1.
REQ-004 SHALL have status ports: busy out 1; tick out 1 (one-cycle pulse per serviced timeout); tick_count out 16; snap_value out 32; snap_valid out 1 (pulse); err_overrun out 1 (sticky).
REQ-005 Slave register map: 0 status (any write clears timeout), 1 control {STOP, START, CONT, ITO}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h; any write to 4 or 5 latches the snapshot.

Function
REQ-006 All outputs SHALL be registered. Bus signals are valid during the cycle the FSM occupies the named state. Each state lasts exactly one cycle unless stated otherwise.
REQ-007 FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP, STOP_WR, STOP_CLR.
REQ-008 IDLE: chipselect=0, write_n=1. When cmd_start=1, the FSM SHALL latch cmd_period and cmd_continuous, clear tick_count and err_overrun, and go to WR_PL.
REQ-009 WR_PL writes address 2 with data period[15:0]. WR_PH writes address 3 with data period[31:16]. WR_CTRL writes address 1 with 0x0007 if continuous, else 0x0005. WR_CTRL then goes to RUN.
REQ-010 RUN: chipselect=0. Priority order is cmd_stop > irq > pending snapshot.
  - cmd_stop -> STOP_WR.
  - irq=1 -> CLR_ST.
  - snap_pend=1 -> SNAP_WR.
REQ-011 CLR_ST writes address 0 with data 0x0000 and pulses tick in the same cycle. tick_count increments, wrapping 0xFFFF -> 0x0000. The next state is RUN if continuous, else STOP_CLR.
REQ-012 snap_req SHALL set snap_pend in any non-IDLE state. A snap_req in IDLE is ignored. snap_pend clears on entry to SNAP_WR. Multiple requests while pending collapse into one.
REQ-013 SNAP_WR writes address 4 with data 0x0000.
REQ-014 SNAP_RL presents address 4 as a read (chipselect=1, write_n=1).
REQ-015 SNAP_RH presents address 5 as a read and captures av_readdata into snap_value[15:0].
REQ-016 SNAP_CAP (chipselect=0) captures av_readdata into snap_value[31:16] and pulses snap_valid, then goes to RUN.
REQ-017 If irq=1 during SNAP_WR..SNAP_CAP, err_overrun SHALL be set. The snapshot sequence is not aborted, and the irq is serviced from RUN afterwards.
REQ-018 STOP_WR writes address 1 with 0x0008. STOP_CLR writes address 0 with 0x0000 and then goes to IDLE.
REQ-019 cmd_start outside IDLE SHALL be ignored. cmd_stop outside RUN SHALL be ignored, except in WR_PL..WR_CTRL, where it is held pending and taken on the first RUN cycle.
REQ-020 busy = (state != IDLE). It is registered and rises the cycle after cmd_start is accepted.
REQ-021 One-shot mode: after CLR_ST the block SHALL pass through STOP_CLR to IDLE. There is no second tick.

Reset
REQ-022 While reset_n=0, the following SHALL hold: state=IDLE; av_chipselect=0; av_write_n=1; av_address=0; av_writedata=0; busy=0; tick=0; tick_count=0; snap_value=0; snap_valid=0; err_overrun=0; snap_pend=0; latched period and mode = 0.
REQ-023 Reset mid-sequence SHALL abort immediately with no further bus cycles. The first bus activity after release requires a new cmd_start.

Verification
REQ-024 Start: cmd_period=0x0001_86A0, cmd_continuous=1 -> three consecutive write cycles: addr2/0x86A0, addr3/0x0001, addr1/0x0007. busy=1 from the first of them.
REQ-025 Continuous run with the slave model, period=9 -> irq every 10 cycles, and each irq produces one CLR_ST write addr0/0x0000 plus one tick. tick_count=3 after the third timeout.
REQ-026 One-shot: cmd_continuous=0, period=4 -> control write 0x0005, then one tick, then STOP_CLR, then IDLE with busy=0. No further bus writes.
REQ-027 Snapshot: snap_req in RUN, slave counter snapshot=0x0002_1234 -> write addr4, read addr4, read addr5. snap_valid pulses with snap_value=0x0002_1234.
REQ-028 Collisions:
  - cmd_stop and irq asserted in the same RUN cycle -> addr1/0x0008 then addr0/0x0000, no tick.
  - irq arriving during a snapshot -> err_overrun=1, tick after SNAP_CAP.
REQ-029 Wrap and reset: tick_count preset to 0xFFFF plus one timeout -> tick_count=0x0000. reset_n asserted in WR_PH -> chipselect=0 the next cycle and all outputs at reset values.
